// File: rtl/mu_tl_pkg.sv
// Shared constants, FSM state type and size helper for the matrix-unit TileLink
// read responder and its beat packer.
package mu_tl_pkg;

  localparam int unsigned TL_ADDR_W      = 21;
  localparam int unsigned TL_SIZE_W      = 4;
  localparam int unsigned TL_SRC_W       = 7;
  localparam int unsigned TL_MAX_LG_SIZE = 8;
  localparam int unsigned TL_DATA_W      = 256;
  localparam int unsigned GLB_DATA_W     = 64;

  localparam logic [2:0]  ACCESS_ACK_DATA = 3'd1;
  localparam int unsigned BEAT_BYTES      = 32;
  localparam int unsigned WORDS_PER_BEAT  = 4;
  localparam int unsigned MIN_LG_SIZE     = 5;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } tl_state_e;

  // Requests smaller than one beat still fetch a full beat; larger ones are capped.
  function automatic int unsigned eff_lg_size(input int unsigned lg_size,
                                              input int unsigned max_lg);
    if (lg_size < MIN_LG_SIZE) return MIN_LG_SIZE;
    if (lg_size > max_lg) return max_lg;
    return lg_size;
  endfunction

endpackage

// File: rtl/mu_tl_beat_packer.sv
// Collects four 64-bit GLB words little-endian into one 256-bit D-channel beat.
module mu_tl_beat_packer
  import mu_tl_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [GLB_DATA_W-1:0] wr_data,
  input  logic                  clr,
  output logic [TL_DATA_W-1:0]  data,
  output logic                  full,
  output logic                  last
);

  logic [1:0] word_cnt;

  assign last = wr_en && (word_cnt == 2'(WORDS_PER_BEAT - 1));

  // Data is left in place on clear; the next beat overwrites every word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      word_cnt <= '0;
      full     <= 1'b0;
      data     <= '0;
    end else if (clr) begin
      word_cnt <= '0;
      full     <= 1'b0;
    end else if (wr_en && !full) begin
      data[{word_cnt, 6'd0} +: GLB_DATA_W] <= wr_data;
      word_cnt <= word_cnt + 2'd1;
      if (last) full <= 1'b1;
    end
  end

endmodule

// File: rtl/mu_glb_tl_responder.sv
// TileLink-style read responder: turns A-channel reads into 4-word GLB bursts per
// 32-byte beat and returns AccessAckData beats on the D channel.
module mu_glb_tl_responder
  import mu_tl_pkg::*;
#(
  parameter int unsigned ADDR_W      = TL_ADDR_W,
  parameter int unsigned SIZE_W      = TL_SIZE_W,
  parameter int unsigned SRC_W       = TL_SRC_W,
  parameter int unsigned MAX_LG_SIZE = TL_MAX_LG_SIZE
) (
  input  logic                  clk_in,
  input  logic                  reset_in,
  input  logic                  mu_tl_rq_in_vld,
  output logic                  mu_tl_rq_in_rdy,
  input  logic [ADDR_W-1:0]     mu_tl_addr_in,
  input  logic [SIZE_W-1:0]     mu_tl_size_in,
  input  logic [SRC_W-1:0]      mu_tl_source_in,
  output logic                  mu_tl_resp_out_vld,
  input  logic                  mu_tl_resp_out_rdy,
  output logic [TL_DATA_W-1:0]  mu_tl_data_out,
  output logic [SIZE_W-1:0]     mu_tl_size_out,
  output logic [SRC_W-1:0]      mu_tl_source_out,
  output logic [2:0]            mu_tl_opcode_out,
  output logic                  glb_rd_en,
  output logic [ADDR_W-1:0]     glb_rd_addr,
  input  logic [GLB_DATA_W-1:0] glb_rd_data,
  input  logic                  glb_rd_data_valid,
  output logic                  err_spurious_rd
);

  localparam int unsigned BEAT_CNT_W = MAX_LG_SIZE - MIN_LG_SIZE + 1;
  localparam logic [ADDR_W-1:0] ALL_ONES = '1;

  tl_state_e             state;
  logic                  rq_rdy, resp_vld, rd_en, err;
  logic [ADDR_W-1:0]     rd_addr, beat_base, next_base, req_base, word_off;
  logic [SIZE_W-1:0]     size_q;
  logic [SRC_W-1:0]      src_q;
  logic [2:0]            opcode_q;
  logic [BEAT_CNT_W-1:0] beats_rem, req_beats;
  logic [2:0]            issue_cnt;
  int unsigned           esz;
  logic                  pk_wr, pk_clr, pk_full, pk_last, spurious;

  assign esz       = eff_lg_size(32'(mu_tl_size_in), MAX_LG_SIZE);
  assign req_base  = mu_tl_addr_in & (ALL_ONES << esz);
  assign req_beats = BEAT_CNT_W'(1) << (esz - MIN_LG_SIZE);
  assign word_off  = ADDR_W'({issue_cnt[1:0], 3'b000});
  assign next_base = beat_base + ADDR_W'(BEAT_BYTES);

  // A word is only taken while a beat is being fetched and not yet complete.
  assign pk_wr    = glb_rd_data_valid && (state == ISSUE || state == WAIT) && !pk_full;
  assign spurious = glb_rd_data_valid && !pk_wr;
  assign pk_clr   = (state == RESP) && mu_tl_resp_out_rdy;

  mu_tl_beat_packer u_packer (
    .clk     (clk_in),
    .rst     (reset_in),
    .wr_en   (pk_wr),
    .wr_data (glb_rd_data),
    .clr     (pk_clr),
    .data    (mu_tl_data_out),
    .full    (pk_full),
    .last    (pk_last)
  );

  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      state     <= IDLE;
      rq_rdy    <= 1'b1;
      resp_vld  <= 1'b0;
      rd_en     <= 1'b0;
      rd_addr   <= '0;
      size_q    <= '0;
      src_q     <= '0;
      opcode_q  <= ACCESS_ACK_DATA;
      err       <= 1'b0;
      beat_base <= '0;
      beats_rem <= '0;
      issue_cnt <= '0;
    end else begin
      opcode_q <= ACCESS_ACK_DATA;
      if (spurious) err <= 1'b1;
      case (state)
        IDLE: if (mu_tl_rq_in_vld) begin
          rq_rdy    <= 1'b0;
          size_q    <= mu_tl_size_in;
          src_q     <= mu_tl_source_in;
          beat_base <= req_base;
          beats_rem <= req_beats;
          rd_en     <= 1'b1;
          rd_addr   <= req_base;
          issue_cnt <= 3'd1;
          state     <= ISSUE;
        end
        // issue_cnt counts reads already launched, so word 0 goes out on entry.
        ISSUE: if (issue_cnt != 3'(WORDS_PER_BEAT)) begin
          rd_en     <= 1'b1;
          rd_addr   <= beat_base + word_off;
          issue_cnt <= issue_cnt + 3'd1;
        end else begin
          rd_en <= 1'b0;
          if (pk_full || pk_last) begin
            state    <= RESP;
            resp_vld <= 1'b1;
          end else begin
            state <= WAIT;
          end
        end
        WAIT: if (pk_last) begin
          state    <= RESP;
          resp_vld <= 1'b1;
        end
        RESP: if (mu_tl_resp_out_rdy) begin
          resp_vld  <= 1'b0;
          beats_rem <= beats_rem - BEAT_CNT_W'(1);
          beat_base <= next_base;
          if (beats_rem != BEAT_CNT_W'(1)) begin
            state     <= ISSUE;
            rd_en     <= 1'b1;
            rd_addr   <= next_base;
            issue_cnt <= 3'd1;
          end else begin
            state  <= IDLE;
            rq_rdy <= 1'b1;
          end
        end
      endcase
    end
  end

  assign mu_tl_rq_in_rdy    = rq_rdy;
  assign mu_tl_resp_out_vld = resp_vld;
  assign mu_tl_size_out     = size_q;
  assign mu_tl_source_out   = src_q;
  assign mu_tl_opcode_out   = opcode_q;
  assign glb_rd_en          = rd_en;
  assign glb_rd_addr        = rd_addr;
  assign err_spurious_rd    = err;

endmodule

// File: doc/mu_glb_tl_responder.md
# mu_glb_tl_responder

Responder end of the matrix-unit-to-global-buffer TileLink-style read channel. It accepts A-channel read requests (address, size, source) from the matrix unit, issues the matching 64-bit read sequence to a global-buffer read port, and packs the returned words into 256-bit D-channel beats. Each request is answered with AccessAckData beats. The block sits inside the CGRA top, between the `mu_tl_*` pins and the GLB read path.

## Interface
Parameters:
- ADDR_W, 21, request/GLB byte-address width
- SIZE_W, 4, log2(bytes) size field width
- SRC_W, 7, source ID width
- MAX_LG_SIZE, 8, largest supported log2 transfer size; 256 B = 8 beats

Ports:
- clk_in  in  1  single clock
- reset_in  in  1  asynchronous, active-high reset
- mu_tl_rq_in_vld  in  1  A-channel valid
- mu_tl_rq_in_rdy  out  1  A-channel ready
- mu_tl_addr_in  in  ADDR_W  request byte address
- mu_tl_size_in  in  SIZE_W  log2 request bytes
- mu_tl_source_in  in  SRC_W  request source ID
- mu_tl_resp_out_vld  out  1  D-channel valid
- mu_tl_resp_out_rdy  in  1  D-channel ready
- mu_tl_data_out  out  256  beat data
- mu_tl_size_out  out  SIZE_W  echoed request size
- mu_tl_source_out  out  SRC_W  echoed source
- mu_tl_opcode_out  out  3  constant 3'd1, AccessAckData
- glb_rd_en  out  1  GLB read strobe, one read per asserted cycle
- glb_rd_addr  out  ADDR_W  GLB byte address, 8-byte aligned
- glb_rd_data  in  64  GLB read data
- glb_rd_data_valid  in  1  GLB data valid; returns in order, latency ≥1, no backpressure
- err_spurious_rd  out  1  sticky flag: GLB data arrived when none was outstanding

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP.
- **IDLE**
  - `rq_in_rdy`=1.
  - On vld&rdy, latch source and size.
  - Effective size: `esz` = max(size, 5) clamped to MAX_LG_SIZE.
  - Beat base address: address with bits [esz-1:0] forced to 0.
  - Beat count: 2^(esz-5).
  - Go to ISSUE.
- **ISSUE**
  - Assert `glb_rd_en` for exactly 4 consecutive cycles.
  - Addresses: beat_base, +8, +16, +24.
  - Then go to WAIT. If all 4 words have already returned, go directly to RESP.
- **WAIT**
  - Count `glb_rd_data_valid` pulses; word k goes to `data_out[64k+63:64k]` (little-endian).
  - The 4th word moves the FSM to RESP on the next cycle.
  - Response words may also arrive during ISSUE; they are counted the same way.
- **RESP**
  - `resp_out_vld`=1. Data, size and source stay stable until `resp_out_rdy`.
  - On handshake: decrement beats remaining, advance beat_base by 32.
  - If beats remain, go to ISSUE; otherwise go to IDLE.
- `mu_tl_size_out` is the original request size, not `esz`.
- Address arithmetic wraps modulo 2^ADDR_W.
- `glb_rd_data_valid` while no read is outstanding (IDLE or RESP, or a 5th word) is dropped and sets `err_spurious_rd`. The flag is cleared only by reset.

## Timing
- Reset values:
  - `rq_in_rdy`=1
  - `resp_out_vld`=0
  - `glb_rd_en`=0
  - `glb_rd_addr`=0
  - `data_out`=0
  - `size_out`=0
  - `source_out`=0
  - `opcode_out`=1
  - `err_spurious_rd`=0
- All outputs are registered.
- `rq_in_rdy` is 0 from the cycle after acceptance until the return to IDLE. No request pipelining: one outstanding request.
- Single-beat latency, with A handshake at cycle 0 and GLB latency L:
  - `glb_rd_en` is high in cycles 1–4.
  - The last word returns in cycle 4+L.
  - `resp_out_vld` rises in cycle 5+L.
- Multi-beat: the next beat's ISSUE starts in the cycle after the D handshake.
- Reset mid-transfer:
  - Immediate return to IDLE; all counters cleared.
  - GLB words still in flight after reset are dropped. The bench must not expect `err_spurious_rd` to stay clear in this case.

## Structure
- `mu_tl_pkg` holds:
  - TL opcode constants (ACCESS_ACK_DATA=3'd1)
  - BEAT_BYTES=32, WORDS_PER_BEAT=4
  - FSM state enum
  - width localparams shared with the top-level wiring
- Sub-module `mu_tl_beat_packer`: a 4×64 to 256 collector with a word counter, a full flag, and a clear on D handshake.

## Test plan
- size=5, addr=0x00040, source=0x12, GLB latency 2 returning 0x0..0 through 0x3..3 → `glb_rd_en` in cycles 1–4 at addresses 0x40/0x48/0x50/0x58. One beat with data {w3,w2,w1,w0}, size_out=5, source_out=0x12, opcode=1, vld rising in cycle 7.
- size=7, addr=0x1FFC0 → 4 beats at bases 0x1FF80, 0x1FFA0, 0x1FFC0, 0x1FFE0. The last beat is flagged complete, then `rq_in_rdy` returns to 1.
- size=8, addr=0x1FFF00 (near top of the 21-bit range) → 8 beats; addresses wrap to 0x000000 only if the increment overflows. Hold `resp_out_rdy`=0 for 10 cycles on beat 3 → data, size and source stay stable.
- size=2 → treated as one 32-byte beat, size_out=2. size=12 → clamped to 8 beats, size_out=12.
- `glb_rd_data_valid` pulsed in IDLE → word ignored, `err_spurious_rd`=1 and sticky across subsequent clean transfers.
- Assert `reset_in` asynchronously during beat 2 of an 8-beat request → outputs at reset values within the same cycle. A new request after reset completes correctly.
